// File: rtl/recip_arb_pkg.sv
// Shared types for the reciprocal arbiter: FSM states, saturation value, round-robin step.
package recip_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  // Returned for X==0; largest positive 24-bit signed value.
  localparam logic [23:0] RECIP_SAT = 24'h7FFFFF;

  function automatic int rr_next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/reciprocal_arbiter_if.sv
// Request/response and reciprocal-unit signals of the arbiter; master = arbiter side.
interface reciprocal_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 24
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_x;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;
  logic [DATA_W-1:0]         ru_x;
  logic                      ru_valid;
  logic [DATA_W-1:0]         ru_result;
  logic                      ru_done;
  logic                      busy;

  modport master (
    input  req_valid, req_x, ru_result, ru_done,
    output req_ready, rsp_valid, rsp_data, rsp_err, ru_x, ru_valid, busy
  );

  modport slave (
    output req_valid, req_x, ru_result, ru_done,
    input  req_ready, rsp_valid, rsp_data, rsp_err, ru_x, ru_valid, busy
  );
endinterface

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first requester after i_last (with wrap) wins; purely combinational.
module rr_priority_picker
  import recip_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  always_comb begin
    int pos;
    o_any = 1'b0;
    o_idx = '0;
    o_gnt = '0;
    pos   = rr_next_idx(int'(i_last), NUM_REQ);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!o_any && i_req[IDX_W'(pos)]) begin
        o_any = 1'b1;
        o_idx = IDX_W'(pos);
      end
      pos = rr_next_idx(pos, NUM_REQ);
    end
    if (o_any) o_gnt[o_idx] = 1'b1;
  end

endmodule

// File: rtl/reciprocal_arbiter.sv
// Shares one reciprocal unit between NUM_REQ requesters with round-robin grant and tagged response.
// RECIP_CACHE_EN adds a one-entry {x,result} cache that bypasses the unit on a repeat divisor.
module reciprocal_arbiter
  import recip_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reciprocal_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_last;
  logic [IDX_W-1:0]    r_tag;
  logic [DATA_W-1:0]   r_x;
  logic [DATA_W-1:0]   r_result;
  logic                r_err;

  logic [NUM_REQ-1:0]  w_gnt;
  logic [IDX_W-1:0]    w_idx;
  logic                w_any;
  logic                w_accept;
  logic [DATA_W-1:0]   w_sel_x;
  logic                w_zero;
  logic                w_hit;
  logic [NUM_REQ-1:0]  w_tag_oh;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_req  (bus.req_valid),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign w_sel_x = bus.req_x[int'(w_idx)*DATA_W +: DATA_W];
  assign w_zero  = (w_sel_x == '0);

`ifdef RECIP_CACHE_EN
  logic              r_c_vld;
  logic [DATA_W-1:0] r_c_x;
  logic [DATA_W-1:0] r_c_res;

  assign w_hit = r_c_vld && (w_sel_x == r_c_x);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_vld <= 1'b0;
      r_c_x   <= '0;
      r_c_res <= '0;
    end else if (r_state == S_WAIT && bus.ru_done) begin
      r_c_vld <= 1'b1;
      r_c_x   <= r_x;
      r_c_res <= bus.ru_result;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_accept    = 1'b1;
          w_state_nxt = (w_zero || w_hit) ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (bus.ru_done) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_last   <= IDX_W'(NUM_REQ - 1);
      r_tag    <= '0;
      r_x      <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_x   <= w_sel_x;
        r_tag <= w_idx;
        r_err <= w_zero;
        if (w_zero) begin
          r_result <= DATA_W'(RECIP_SAT);
        end
`ifdef RECIP_CACHE_EN
        else if (w_hit) begin
          r_result <= r_c_res;
        end
`endif
      end
      if (r_state == S_WAIT && bus.ru_done) r_result <= bus.ru_result;
      if (r_state == S_RESP) r_last <= r_tag;
    end
  end

  assign w_tag_oh      = NUM_REQ'(1) << r_tag;
  assign bus.req_ready = (r_state == S_IDLE) ? w_gnt : '0;
  assign bus.rsp_valid = (r_state == S_RESP) ? w_tag_oh : '0;
  assign bus.rsp_data  = r_result;
  assign bus.rsp_err   = (r_state == S_RESP) && r_err;
  // Latched divisor stays on ru_x for the whole operation.
  assign bus.ru_x      = r_x;
  assign bus.ru_valid  = (r_state == S_ISSUE);
  assign bus.busy      = (r_state != S_IDLE);

endmodule
